// File: rtl/program_memory_loader_if.sv
// Load/fetch bus of the program memory loader.
//   master: CPU / loader side, drives load_* and fetch requests, receives inst and status.
//   slave : program memory side.
// Signals:
//   load_start - pulse, begin a new program load
//   load_valid - load_data carries a word this cycle
//   load_data  - instruction word to store
//   load_end   - pulse, program load complete
//   fetch_en   - fetch the instruction at pc
//   pc         - fetch address
//   inst       - registered instruction
//   inst_valid - inst answers the previous cycle's fetch
//   busy       - memory is being loaded
//   prog_len   - number of loaded words, 0..DEPTH
interface program_memory_loader_if #(
    parameter int unsigned IW    = 10,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
);
    logic          load_start;
    logic          load_valid;
    logic [IW-1:0] load_data;
    logic          load_end;
    logic          fetch_en;
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
    logic          inst_valid;
    logic          busy;
    logic [AW:0]   prog_len;

    modport master (
        output load_start, load_valid, load_data, load_end, fetch_en, pc,
        input  inst, inst_valid, busy, prog_len
    );

    modport slave (
        input  load_start, load_valid, load_data, load_end, fetch_en, pc,
        output inst, inst_valid, busy, prog_len
    );
endinterface

// File: rtl/program_memory_loader.sv
// Run-time loadable instruction memory for the Ra/Rb accumulator CPU.
// A sequential load port fills a DEPTH x IW store; a registered fetch port serves the PC with
// one cycle of latency. Addresses at or beyond the loaded length return FILL_INST.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - program_memory_loader_if slave modport (load port, fetch port, status)
module program_memory_loader #(
    parameter int unsigned   IW        = 10,
    parameter int unsigned   DEPTH     = 16,
    parameter int unsigned   AW        = $clog2(DEPTH),
    parameter logic [IW-1:0] FILL_INST = 10'b10_1100_0000
) (
    input logic                      clk,
    input logic                      rst_n,
    program_memory_loader_if.slave   bus
);

    typedef enum logic [0:0] {StRun, StLoad} state_e;

    state_e        state_q;
    // One bit wider than the address so it can reach DEPTH; it always equals prog_len.
    logic [AW:0]   wr_ptr_q;
    logic [IW-1:0] inst_q;
    logic          inst_valid_q;
    logic [IW-1:0] mem [DEPTH];

    logic mem_we;
    logic last_write;
    logic pc_hit;

    // load_start in LOAD restarts the load and drops a simultaneous word.
    assign mem_we     = (state_q == StLoad) && bus.load_valid && !bus.load_start;
    assign last_write = (wr_ptr_q == (AW+1)'(DEPTH - 1));
    assign pc_hit     = ({1'b0, bus.pc} < wr_ptr_q);

    // Storage is deliberately not reset; prog_len=0 hides its contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            wr_ptr_q     <= '0;
            inst_q       <= FILL_INST;
            inst_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.fetch_en) begin
                        inst_q       <= pc_hit ? mem[bus.pc] : FILL_INST;
                        inst_valid_q <= 1'b1;
                    end else begin
                        inst_valid_q <= 1'b0;
                    end
                    if (bus.load_start) begin
                        state_q  <= StLoad;
                        wr_ptr_q <= '0;
                    end
                end
                StLoad: begin
                    inst_q       <= FILL_INST;
                    inst_valid_q <= 1'b0;
                    if (bus.load_start) begin
                        wr_ptr_q <= '0;
                    end else begin
                        if (bus.load_valid) begin
                            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                        end
                        // Filling the last word ends the load even without load_end.
                        if (bus.load_end || (bus.load_valid && last_write)) begin
                            state_q <= StRun;
                        end
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.busy       = (state_q == StLoad);
    assign bus.prog_len   = wr_ptr_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
module tb_program_memory_loader;

    localparam int unsigned IW    = 10;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic [IW-1:0] FILL = 10'h2C0;

    logic clk;
    logic rst_n;

    program_memory_loader_if #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) bus ();

    program_memory_loader #(.IW(IW), .DEPTH(DEPTH), .AW(AW), .FILL_INST(FILL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a list of loaded words plus a "loading" flag.
    logic [IW-1:0] m_mem [DEPTH];
    int            m_len;
    bit            m_loading;
    logic [IW-1:0] m_inst;
    bit            m_valid;
    bit            model_on = 1'b0;

    task automatic model_reset();
        m_len     = 0;
        m_loading = 1'b0;
        m_inst    = FILL;
        m_valid   = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs that were present at that edge.
    task automatic model_step();
        if (m_loading) begin
            m_inst  = FILL;
            m_valid = 1'b0;
            if (bus.load_start) begin
                m_len = 0;
            end else begin
                if (bus.load_valid) begin
                    m_mem[m_len] = bus.load_data;
                    m_len++;
                end
                if (bus.load_end || m_len == DEPTH) m_loading = 1'b0;
            end
        end else begin
            if (bus.fetch_en) begin
                m_inst  = (int'(bus.pc) < m_len) ? m_mem[bus.pc] : FILL;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (bus.load_start) begin
                m_loading = 1'b1;
                m_len     = 0;
            end
        end
    endtask

    // Single compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (model_on && rst_n) begin
            check("busy",       32'(bus.busy),       32'(m_loading));
            check("prog_len",   32'(bus.prog_len),   32'(m_len));
            check("inst_valid", 32'(bus.inst_valid), 32'(m_valid));
            check("inst",       32'(bus.inst),       32'(m_inst));
        end
    end

    // Apply one cycle of inputs (from a falling edge), step the model, return at the next fall.
    task automatic drive(input bit ls, input bit lv, input logic [IW-1:0] ld, input bit le,
                         input bit fe, input int p);
        bus.load_start = ls;
        bus.load_valid = lv;
        bus.load_data  = ld;
        bus.load_end   = le;
        bus.fetch_en   = fe;
        bus.pc         = AW'(p);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 0);
    endtask

    task automatic fetch(input int p);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, p);
    endtask

    task automatic load_word(input logic [IW-1:0] w, input bit le);
        drive(1'b0, 1'b1, w, le, 1'b0, 0);
    endtask

    logic [IW-1:0] prog [12] = '{10'h021, 10'h3E1, 10'h020, 10'h3E2, 10'h3F0, 10'h321,
                                 10'h362, 10'h3F0, 10'h3E2, 10'h000, 10'h1C0, 10'h2C6};
    logic [IW-1:0] full_words [DEPTH];
    logic [IW-1:0] w_a;
    logic [IW-1:0] w_b;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_end   = 1'b0;
        bus.fetch_en   = 1'b0;
        bus.pc         = '0;
        model_reset();
        // load_start during reset must be ignored.
        @(negedge clk);
        bus.load_start = 1'b1;
        @(negedge clk);
        bus.load_start = 1'b0;
        rst_n    = 1'b1;
        model_on = 1'b1;
        #1;
        check("reset_busy",       32'(bus.busy),       0);
        check("reset_prog_len",   32'(bus.prog_len),   0);
        check("reset_inst",       32'(bus.inst),       32'h2C0);
        check("reset_inst_valid", 32'(bus.inst_valid), 0);
        @(negedge clk);

        // Post-reset fetches return the fill word.
        foreach (prog[k]) if (k < 3) begin
            fetch(k == 0 ? 0 : (k == 1 ? 5 : 15));
            check("post_reset_inst",  32'(bus.inst),       32'h2C0);
            check("post_reset_valid", 32'(bus.inst_valid), 1);
        end

        // 12-word program load.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
        check("load_busy", 32'(bus.busy), 1);
        for (int i = 0; i < 12; i++) load_word(prog[i], 1'b0);
        check("load_busy_end", 32'(bus.busy), 1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 0);
        check("load_done_busy", 32'(bus.busy), 0);
        check("load_prog_len",  32'(bus.prog_len), 12);
        for (int i = 0; i <= 12; i++) begin
            fetch(i);
            check("prog_fetch", 32'(bus.inst), (i < 12) ? 32'(prog[i]) : 32'h2C0);
        end
        idle();

        // Full load with no load_end.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            full_words[i] = IW'($urandom);
            load_word(full_words[i], 1'b0);
        end
        check("full_busy",     32'(bus.busy), 0);
        check("full_prog_len", 32'(bus.prog_len), 16);
        load_word(10'h155, 1'b0);
        check("full_17th_len", 32'(bus.prog_len), 16);
        for (int i = 0; i < DEPTH; i++) begin
            fetch(i);
            check("full_fetch", 32'(bus.inst), 32'(full_words[i]));
        end

        // Restart with a simultaneous word, then a 2-word load ending on the 2nd word.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) load_word(IW'($urandom), 1'b0);
        drive(1'b1, 1'b1, 10'h3AA, 1'b0, 1'b0, 0);
        check("restart_len",  32'(bus.prog_len), 0);
        check("restart_busy", 32'(bus.busy), 1);
        w_a = 10'h0A5;
        w_b = 10'h15A;
        load_word(w_a, 1'b0);
        load_word(w_b, 1'b1);
        check("short_len",  32'(bus.prog_len), 2);
        check("short_busy", 32'(bus.busy), 0);
        fetch(1);
        check("short_pc1", 32'(bus.inst), 32'(w_b));
        fetch(0);
        check("short_pc0", 32'(bus.inst), 32'(w_a));
        fetch(2);
        check("short_pc2", 32'(bus.inst), 32'h2C0);

        // Fetch requests during a load are ignored.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, IW'(i + 7), 1'b0, 1'b1, i);
            check("load_fetch_valid", 32'(bus.inst_valid), 0);
            check("load_fetch_inst",  32'(bus.inst), 32'h2C0);
        end
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 0);
        check("load_end_valid", 32'(bus.inst_valid), 0);
        fetch(3);
        check("after_load_valid", 32'(bus.inst_valid), 1);
        check("after_load_inst",  32'(bus.inst), 32'd10);

        // Asynchronous reset in the middle of a load.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) load_word(IW'(i + 1), 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_busy",     32'(bus.busy), 0);
        check("midrst_prog_len", 32'(bus.prog_len), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fetch(0);
        check("midrst_fetch", 32'(bus.inst), 32'h2C0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1), IW'($urandom),
                  ($urandom_range(0, 14) == 0), ($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, DEPTH - 1)));
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
